id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of the fetch stage's IF/ID register.
- Decodes the 32-bit instruction, reads a 32x32 register file written by write-back, and generates datapath control.
- Detects load-use hazards and computes jump redirects for fetch.
- Registers everything into the ID/EX pipeline register consumed by execute.

Parameters:
- NREGS, 32, register-file depth; register 0 hardwired to zero.
- DW, 32, data and PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- instr_in  in  32  instruction from IF/ID register.
- pc_in  in  32  word-indexed PC from IF/ID register.
- wb_we  in  1  write-back enable.
- wb_addr  in  5  write-back destination register.
- wb_data  in  32  write-back data.
- ex_mem_read  in  1  MemRead of the instruction currently in EX.
- ex_rt  in  5  destination rt of the instruction currently in EX.
- flush  in  1  PCSrc from the mem stage (branch taken).
- stall  out  1  combinational; IF must hold the PC and the IF/ID register.
- jump  out  1  combinational jump request to fetch.
- jump_add  out  26  instr_in[25:0].
- idex_pc, idex_rs_data, idex_rt_data, idex_imm  out  32 each  registered; idex_imm = sign-extended instr_in[15:0].
- idex_rs, idex_rt, idex_rd  out  5 each  registered.
- idex_funct  out  6  registered.
- idex_reg_dst, idex_alu_src, idex_mem_to_reg, idex_reg_write, idex_mem_read, idex_mem_write, idex_branch  out  1 each  registered.
- idex_alu_op  out  2  registered.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All idex_* outputs are cleared to 0.
  - All register-file entries are cleared to 0.
- Register file:
  - Writes occur on the rising edge when wb_we=1 and wb_addr!=0.
  - Writes to register 0 are ignored; register 0 always reads 0.
  - Reads are combinational on instr_in[25:21] (rs) and instr_in[20:16] (rt).
- Decode, by opcode instr_in[31:26]. Control order is reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op:
  - 000000 R-type: 1,0,0,1,0,0,0,10.
  - 100011 lw: 0,1,1,1,1,0,0,00.
  - 101011 sw: 0,1,0,0,0,1,0,00.
  - 000100 beq: 0,0,0,0,0,0,1,01.
  - 000010 j: all controls 0.
  - Any other opcode: all controls 0 (bubble).
  - instr_in == 0 is a nop: all controls 0.
- Latency: one cycle. Values decoded from IF/ID at edge N appear on idex_* after edge N+1.
- Load-use hazard:
  - stall = ex_mem_read AND ex_rt!=0 AND (ex_rt==rs OR (ex_rt==rt AND opcode in {R-type, sw, beq})).
  - While stall=1, ID/EX captures a bubble: every idex_* field is 0.
  - The stalled instruction stays in IF/ID and is re-decoded the next cycle.
- Flush:
  - flush=1 forces ID/EX to capture a bubble.
  - flush also forces stall=0 and jump=0, so fetch loads the branch target.
  - flush has priority over stall and jump.
- Jump:
  - jump = (opcode==000010) AND NOT stall AND NOT flush.
  - jump_add is always instr_in[25:0].
  - The jump instruction itself enters ID/EX as a bubble.
  - The instruction fetched in the same cycle (delay slot) is not squashed and executes normally.
- Simultaneous events:
  - rst overrides flush, stall and writes.
  - A register-file write and ID/EX capture in the same edge are independent.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - A same-cycle write is forwarded to the read ports.
  - If wb_we=1, wb_addr!=0 and wb_addr matches rs (or rt), that read returns wb_data instead of the stored value.
- Undefined:
  - Reads return the stored value only.
  - A write landing in the same cycle becomes visible on the next cycle.

Test Plan:
- Reset, then R-type check:
  - Stimulus: rst=1 for 2 cycles, release; load $16=5 and $17=7 via write-back; apply instr 0x02114020 (add $8,$16,$17).
  - Response: idex_rs_data=5, idex_rt_data=7, idex_rd=8, idex_reg_write=1, idex_alu_op=10 one cycle later.
- Register 0 protection:
  - Stimulus: wb_we=1, wb_addr=0, wb_data=0xDEADBEEF; then read rs=0.
  - Response: idex_rs_data=0.
- Load-use stall:
  - Stimulus: ex_mem_read=1, ex_rt=8; instr 0x01094820 (add $9,$8,$9).
  - Response: stall=1; all idex_* =0 next cycle.
  - Stimulus: same with ex_rt=0.
  - Response: stall=0.
- Jump:
  - Stimulus: instr 0x0800000C.
  - Response: jump=1, jump_add=0x00000C; ID/EX bubble.
  - Stimulus: same instruction with flush=1.
  - Response: jump=0, stall=0.
- Bypass:
  - Stimulus: wb_we=1, wb_addr=16, wb_data=0x55 in the same cycle as a read of rs=16 whose stored value is 3.
  - Response: idex_rs_data=0x55 with ID_WB_BYPASS_EN defined; idex_rs_data=3 without it.
- lw decode with negative offset:
  - Stimulus: instr 0x8E28FFFC.
  - Response: idex_imm=0xFFFFFFFC, idex_mem_read=1, idex_mem_to_reg=1, idex_alu_src=1.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: register file, control decode, load-use hazard and jump detection, ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write-back to the register read ports.
module id_stage #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_in,
  input  logic [DW-1:0] pc_in,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ex_mem_read,
  input  logic [4:0]    ex_rt,
  input  logic          flush,
  output logic          stall,
  output logic          jump,
  output logic [25:0]   jump_add,
  output logic [DW-1:0] idex_pc,
  output logic [DW-1:0] idex_rs_data,
  output logic [DW-1:0] idex_rt_data,
  output logic [DW-1:0] idex_imm,
  output logic [4:0]    idex_rs,
  output logic [4:0]    idex_rt,
  output logic [4:0]    idex_rd,
  output logic [5:0]    idex_funct,
  output logic          idex_reg_dst,
  output logic          idex_alu_src,
  output logic          idex_mem_to_reg,
  output logic          idex_reg_write,
  output logic          idex_mem_read,
  output logic          idex_mem_write,
  output logic          idex_branch,
  output logic [1:0]    idex_alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  logic [5:0]    opcode;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [5:0]    funct;
  logic [DW-1:0] imm_ext;
  logic          unused_shamt;

  assign opcode       = instr_in[31:26];
  assign rs           = instr_in[25:21];
  assign rt           = instr_in[20:16];
  assign rd           = instr_in[15:11];
  assign funct        = instr_in[5:0];
  assign imm_ext      = {{(DW-16){instr_in[15]}}, instr_in[15:0]};
  assign unused_shamt = ^instr_in[10:6];

  logic [DW-1:0] regs [NREGS];
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rs_data = (rs == 5'd0) ? '0 : regs[rs];
    rt_data = (rt == 5'd0) ? '0 : regs[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr != 5'd0 && wb_addr == rs) rs_data = wb_data;
    if (wb_we && wb_addr != 5'd0 && wb_addr == rt) rt_data = wb_data;
`endif
  end

  ctrl_t dec;
  logic  dec_valid;
  logic  uses_rt;

  // Only R-type, lw, sw and beq produce work for execute; everything else (j, nop, unknown) is a bubble.
  always_comb begin
    dec       = '0;
    dec_valid = 1'b0;
    uses_rt   = 1'b0;
    if (instr_in != 32'd0) begin
      case (opcode)
        OP_RTYPE: begin dec = ctrl_t'(9'b1_0_0_1_0_0_0_10); dec_valid = 1'b1; end
        OP_LW:    begin dec = ctrl_t'(9'b0_1_1_1_1_0_0_00); dec_valid = 1'b1; end
        OP_SW:    begin dec = ctrl_t'(9'b0_1_0_0_0_1_0_00); dec_valid = 1'b1; end
        OP_BEQ:   begin dec = ctrl_t'(9'b0_0_0_0_0_0_1_01); dec_valid = 1'b1; end
        default:  begin dec = '0; dec_valid = 1'b0; end
      endcase
    end
    uses_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  end

  logic bubble;

  assign stall    = !flush && ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == rs) || ((ex_rt == rt) && uses_rt));
  assign jump     = (opcode == OP_J) && !stall && !flush;
  assign jump_add = instr_in[25:0];
  assign bubble   = flush || stall || !dec_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      idex_pc         <= '0;
      idex_rs_data    <= '0;
      idex_rt_data    <= '0;
      idex_imm        <= '0;
      idex_rs         <= '0;
      idex_rt         <= '0;
      idex_rd         <= '0;
      idex_funct      <= '0;
      idex_reg_dst    <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_branch     <= 1'b0;
      idex_alu_op     <= 2'b00;
    end else begin
      idex_pc         <= pc_in;
      idex_rs_data    <= rs_data;
      idex_rt_data    <= rt_data;
      idex_imm        <= imm_ext;
      idex_rs         <= rs;
      idex_rt         <= rt;
      idex_rd         <= rd;
      idex_funct      <= funct;
      idex_reg_dst    <= dec.reg_dst;
      idex_alu_src    <= dec.alu_src;
      idex_mem_to_reg <= dec.mem_to_reg;
      idex_reg_write  <= dec.reg_write;
      idex_mem_read   <= dec.mem_read;
      idex_mem_write  <= dec.mem_write;
      idex_branch     <= dec.branch;
      idex_alu_op     <= dec.alu_op;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: vector table, directed corner sequences and randomized traffic vs a reference model.
// Honours ID_WB_BYPASS_EN the same way the design does.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [8:0]  ctrl;
  } idex_t;

  typedef struct {
    logic [31:0] instr;
    logic        mr;
    logic [4:0]  ert;
    logic        fl;
    logic        exp_stall;
    logic        exp_jump;
    logic [8:0]  exp_ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        flush;
  logic        stall;
  logic        jump;
  logic [25:0] jump_add;
  logic [31:0] idex_pc, idex_rs_data, idex_rt_data, idex_imm;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [5:0]  idex_funct;
  logic        idex_reg_dst, idex_alu_src, idex_mem_to_reg, idex_reg_write;
  logic        idex_mem_read, idex_mem_write, idex_branch;
  logic [1:0]  idex_alu_op;

  idex_t       dut_idex;
  logic [31:0] model_regs [32];
  int          total = 0;
  int          bad = 0;
  vec_t        vecs [14];

  always #5 clk = ~clk;

  id_stage #(.NREGS(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .flush(flush),
    .stall(stall), .jump(jump), .jump_add(jump_add),
    .idex_pc(idex_pc), .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data),
    .idex_imm(idex_imm), .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
    .idex_funct(idex_funct), .idex_reg_dst(idex_reg_dst), .idex_alu_src(idex_alu_src),
    .idex_mem_to_reg(idex_mem_to_reg), .idex_reg_write(idex_reg_write),
    .idex_mem_read(idex_mem_read), .idex_mem_write(idex_mem_write),
    .idex_branch(idex_branch), .idex_alu_op(idex_alu_op)
  );

  assign dut_idex = {idex_pc, idex_rs_data, idex_rt_data, idex_imm, idex_rs, idex_rt, idex_rd,
                     idex_funct, idex_reg_dst, idex_alu_src, idex_mem_to_reg, idex_reg_write,
                     idex_mem_read, idex_mem_write, idex_branch, idex_alu_op};

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Control word {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op} from the opcode table.
  function automatic logic [8:0] model_ctrl(input logic [31:0] instr);
    if (instr == 32'd0) return 9'd0;
    case (instr[31:26])
      6'h00:   return 9'b100100010;
      6'h23:   return 9'b011110000;
      6'h2b:   return 9'b010001000;
      6'h04:   return 9'b000000101;
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] waddr, input logic [31:0] wdata);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (we && waddr == a) return wdata;
`endif
    return model_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
  endtask

  // One decode cycle: drive, check the combinational outputs, clock, check what ID/EX captured.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                               input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic mr, input logic [4:0] ert, input logic fl);
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       uses_rt, exp_stall, exp_jump;
    logic [8:0] ctrl;
    idex_t      exp;
    instr_in = instr; pc_in = pc; wb_we = we; wb_addr = waddr; wb_data = wdata;
    ex_mem_read = mr; ex_rt = ert; flush = fl;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
    uses_rt   = (op == 6'h00) || (op == 6'h2b) || (op == 6'h04);
    exp_stall = !fl && mr && ert != 5'd0 && (ert == rs || (ert == rt && uses_rt));
    exp_jump  = (op == 6'h02) && !exp_stall && !fl;
    ctrl      = model_ctrl(instr);
    if (fl || exp_stall || ctrl == 9'd0) exp = '0;
    else exp = '{pc: pc, rs_data: model_read(rs, we, waddr, wdata),
                 rt_data: model_read(rt, we, waddr, wdata),
                 imm: {{16{instr[15]}}, instr[15:0]}, rs: rs, rt: rt,
                 rd: instr[15:11], funct: instr[5:0], ctrl: ctrl};
    #1;
    checkOutput("stall", stall, exp_stall);
    checkOutput("jump", jump, exp_jump);
    checkOutput("jump_add", jump_add, instr[25:0]);
    @(posedge clk);
    #1;
    checkOutput("idex", dut_idex, exp);
    if (we && waddr != 5'd0) model_regs[waddr] = wdata;
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] r;
    logic [31:0] rinstr;
    logic [4:0]  rert;

    vecs[0]  = '{32'h02114020, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 9'b100100010};
    vecs[1]  = '{32'h8E28FFFC, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 9'b011110000};
    vecs[2]  = '{32'hAE28FFFC, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 9'b010001000};
    vecs[3]  = '{32'h12110003, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 9'b000000101};
    vecs[4]  = '{32'h0800000C, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 9'd0};
    vecs[5]  = '{32'h0800000C, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 9'd0};
    vecs[6]  = '{32'h01094820, 1'b1, 5'd8,  1'b0, 1'b1, 1'b0, 9'd0};
    vecs[7]  = '{32'h01094820, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 9'b100100010};
    vecs[8]  = '{32'h01094820, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 9'd0};
    vecs[9]  = '{32'h8E28FFFC, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0, 9'b011110000};
    vecs[10] = '{32'h8E28FFFC, 1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 9'd0};
    vecs[11] = '{32'h12110003, 1'b1, 5'd17, 1'b0, 1'b1, 1'b0, 9'd0};
    vecs[12] = '{32'hFC000000, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 9'd0};
    vecs[13] = '{32'h00000000, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 9'd0};
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h3f};

    // Reset must win over a pending write and a decodable instruction.
    rst = 1'b1; instr_in = 32'h02114020; pc_in = 32'h40; wb_we = 1'b1; wb_addr = 5'd16;
    wb_data = 32'h99; ex_mem_read = 1'b0; ex_rt = 5'd0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_idex", dut_idex, 192'd0);
    rst = 1'b0;
    model_clear();

    applyStimulus(32'h02114020, 32'h1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("reset_blocks_write", idex_rs_data, 32'd0);

    applyStimulus(32'h0, 32'h2, 1'b1, 5'd16, 32'd5, 1'b0, 5'd0, 1'b0);
    applyStimulus(32'h0, 32'h3, 1'b1, 5'd17, 32'd7, 1'b0, 5'd0, 1'b0);
    applyStimulus(32'h02114020, 32'h4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("rtype_rs_data", idex_rs_data, 32'd5);
    checkOutput("rtype_rt_data", idex_rt_data, 32'd7);
    checkOutput("rtype_rd", idex_rd, 5'd8);
    checkOutput("rtype_reg_write", idex_reg_write, 1'b1);
    checkOutput("rtype_alu_op", idex_alu_op, 2'b10);

    applyStimulus(32'h0, 32'h5, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    applyStimulus(32'h00004020, 32'h6, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("reg0_rs_data", idex_rs_data, 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].instr, 32'h100 + i, 1'b0, 5'd0, 32'd0, vecs[i].mr, vecs[i].ert, vecs[i].fl);
      checkOutput("vec_stall", stall, vecs[i].exp_stall);
      checkOutput("vec_jump", jump, vecs[i].exp_jump);
      checkOutput("vec_ctrl", dut_idex.ctrl, vecs[i].exp_ctrl);
    end
    checkOutput("lw_imm", idex_imm, 32'd0);
    applyStimulus(32'h8E28FFFC, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("lw_imm_neg", idex_imm, 32'hFFFFFFFC);

    applyStimulus(32'h0, 32'h7, 1'b1, 5'd16, 32'd3, 1'b0, 5'd0, 1'b0);
    applyStimulus(32'h02114020, 32'h8, 1'b1, 5'd16, 32'h55, 1'b0, 5'd0, 1'b0);
`ifdef ID_WB_BYPASS_EN
    checkOutput("bypass_rs_data", idex_rs_data, 32'h55);
`else
    checkOutput("bypass_rs_data", idex_rs_data, 32'd3);
`endif
    applyStimulus(32'h02114020, 32'h9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("after_write_rs_data", idex_rs_data, 32'h55);

    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      rinstr = {ops[$urandom_range(0, 5)], r[25:0]};
      if ($urandom_range(0, 15) == 0) rinstr = 32'd0;
      rert = ($urandom_range(0, 2) == 0) ? rinstr[25:21] : 5'($urandom_range(0, 31));
      applyStimulus(rinstr, $urandom(), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)),
                    $urandom(), ($urandom_range(0, 1) == 1), rert, ($urandom_range(0, 9) == 0));
    end

    // A mid-run reset clears the register file as well as ID/EX.
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrun_reset_idex", dut_idex, 192'd0);
    rst = 1'b0;
    model_clear();
    applyStimulus(32'h02114020, 32'hA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("midrun_reset_regs", idex_rs_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
